// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, default
// address map and the PC legality helper.
package fetch_stage_pkg;

   // Next-PC select codes driven by Decode; codes 4..7 behave as SEQ.
   typedef enum logic [2:0] {
      PCSEL_SEQ = 3'd0,
      PCSEL_BR  = 3'd1,
      PCSEL_J   = 3'd2,
      PCSEL_JR  = 3'd3
   } pc_sel_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
   localparam int          DEF_IM_AW    = 12;
   localparam logic [31:0] NOP          = 32'h0000_0000;

   // A PC is legal when word aligned and inside [base, base + 4*2^aw).
   // The upper limit is formed in 33 bits so a map ending at 4 GiB works.
   function automatic logic pc_is_legal(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input int          aw);
      logic [32:0] limit;
      limit = {1'b0, base} + (33'd4 << aw);
      return (pc[1:0] == 2'b00) &&
             (pc >= base) &&
             ({1'b0, pc} < limit);
   endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Next-PC computation: sequential, PC-relative branch, region jump and
// register jump. Purely combinational; all sums wrap modulo 2^32.
module npc_unit
   import fetch_stage_pkg::*;
(
   input  logic [2:0]  pc_sel_i,
   input  logic [31:0] f_pc_i,
   input  logic [31:0] d_pc_i,
   input  logic [31:0] d_instr_i,
   input  logic [31:0] d_shift_i,
   input  logic [31:0] d_rs_i,
   output logic [31:0] npc_o
);

   logic [31:0] d_pc_plus4;

   assign d_pc_plus4 = d_pc_i + 32'd4;

   // Select the next fetch address; control targets are relative to the
   // instruction in D, so the delay-slot word in F is never skipped.
   always_comb begin
      npc_o = f_pc_i + 32'd4;
      case (pc_sel_i)
         PCSEL_BR: npc_o = d_pc_plus4 + d_shift_i;
         PCSEL_J:  npc_o = {d_pc_plus4[31:28], d_instr_i[25:0], 2'b00};
         PCSEL_JR: npc_o = d_rs_i;
         default:  npc_o = f_pc_i + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the architectural PC, drives the instruction-memory
// word index and loads the F/D register feeding Decode. Illegal PCs feed a
// nop into D and set a sticky fault flag without disturbing PC flow.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
   parameter int          IM_AW    = DEF_IM_AW
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       PC_sel,
   input  logic [31:0]      D_Shift_out,
   input  logic [31:0]      D_rs_trans,
   output logic [IM_AW-1:0] im_addr,
   input  logic [31:0]      im_rdata,
   output logic [31:0]      F_PC,
   output logic [31:0]      out_D_PC,
   output logic [31:0]      out_D_instruction,
   output logic             D_valid,
   output logic             pc_fault
);

   logic [31:0] f_pc_q,     f_pc_d;
   logic [31:0] d_pc_q,     d_pc_d;
   logic [31:0] d_instr_q,  d_instr_d;
   logic        d_valid_q,  d_valid_d;
   logic        pc_fault_q, pc_fault_d;

   logic [31:0] npc;
   logic [31:0] pc_offset;
   logic        pc_legal;
   logic [31:0] fetched_word;

   npc_unit u_npc (
      .pc_sel_i  (PC_sel),
      .f_pc_i    (f_pc_q),
      .d_pc_i    (d_pc_q),
      .d_instr_i (d_instr_q),
      .d_shift_i (D_Shift_out),
      .d_rs_i    (D_rs_trans),
      .npc_o     (npc)
   );

   // Word index relative to the IM base; out-of-range PCs still produce an
   // index, but the fetched word is discarded below.
   assign pc_offset    = f_pc_q - IM_BASE;
   assign im_addr      = pc_offset[IM_AW+1:2];
   assign pc_legal     = pc_is_legal(f_pc_q, IM_BASE, IM_AW);
   assign fetched_word = pc_legal ? im_rdata : NOP;

   // Next-state: stall holds everything (PC_sel ignored), otherwise advance.
   always_comb begin
      f_pc_d     = f_pc_q;
      d_pc_d     = d_pc_q;
      d_instr_d  = d_instr_q;
      d_valid_d  = d_valid_q;
      pc_fault_d = pc_fault_q;
      if (!stall) begin
         f_pc_d     = npc;
         d_pc_d     = f_pc_q;
         d_instr_d  = fetched_word;
         d_valid_d  = pc_legal;
         pc_fault_d = pc_fault_q | ~pc_legal;
      end
   end

   // State registers; synchronous active-low reset beats stall and redirect.
   always_ff @(posedge clk) begin
      if (!reset) begin
         f_pc_q     <= RESET_PC;
         d_pc_q     <= 32'h0;
         d_instr_q  <= NOP;
         d_valid_q  <= 1'b0;
         pc_fault_q <= 1'b0;
      end else begin
         f_pc_q     <= f_pc_d;
         d_pc_q     <= d_pc_d;
         d_instr_q  <= d_instr_d;
         d_valid_q  <= d_valid_d;
         pc_fault_q <= pc_fault_d;
      end
   end

   assign F_PC              = f_pc_q;
   assign out_D_PC          = d_pc_q;
   assign out_D_instruction = d_instr_q;
   assign D_valid           = d_valid_q;
   assign pc_fault          = pc_fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The driver applies one cycle of inputs and,
// right after the edge, queues the hand-computed state expected from it; the
// monitor pops on the following falling edge and compares every output.
module tb_fetch_stage;

   localparam int EW = 98;  // {f_pc, d_pc, d_ins, d_valid, fault}

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [2:0]  PC_sel;
   logic [31:0] D_Shift_out;
   logic [31:0] D_rs_trans;
   logic [11:0] im_addr;
   logic [31:0] im_rdata;
   logic [31:0] F_PC;
   logic [31:0] out_D_PC;
   logic [31:0] out_D_instruction;
   logic        D_valid;
   logic        pc_fault;

   logic [31:0] im_mem [0:4095];
   logic [EW-1:0] exp_q[$];

   int checks   = 0;
   int failures = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   assign im_rdata = im_mem[im_addr];

   fetch_stage dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .PC_sel            (PC_sel),
      .D_Shift_out       (D_Shift_out),
      .D_rs_trans        (D_rs_trans),
      .im_addr           (im_addr),
      .im_rdata          (im_rdata),
      .F_PC              (F_PC),
      .out_D_PC          (out_D_PC),
      .out_D_instruction (out_D_instruction),
      .D_valid           (D_valid),
      .pc_fault          (pc_fault)
   );

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: state after each driven edge is compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [EW-1:0] e;
         logic [31:0]   e_pc, e_off;
         e     = exp_q.pop_front();
         e_pc  = e[97:66];
         e_off = e_pc - 32'h3000;
         chk("F_PC",      F_PC,              e_pc);
         chk("im_addr",   {20'h0, im_addr},  {20'h0, e_off[13:2]});
         chk("D_PC",      out_D_PC,          e[65:34]);
         chk("D_instr",   out_D_instruction, e[33:2]);
         chk("D_valid",   {31'h0, D_valid},  {31'h0, e[1]});
         chk("pc_fault",  {31'h0, pc_fault}, {31'h0, e[0]});
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic rst, input logic st, input logic [2:0] sel,
                       input logic [31:0] sh, input logic [31:0] rs,
                       input logic [31:0] e_fpc, input logic [31:0] e_dpc,
                       input logic [31:0] e_ins, input logic e_v, input logic e_f);
      reset       = rst;
      stall       = st;
      PC_sel      = sel;
      D_Shift_out = sh;
      D_rs_trans  = rs;
      @(posedge clk);
      exp_q.push_back({e_fpc, e_dpc, e_ins, e_v, e_f});
      #1;
   endtask

   initial begin
      for (int k = 0; k < 4096; k++) im_mem[k] = k + 1;

      // Reset, then sequential fetch with IM[k] = k+1.
      step(0, 0, 3'd0, 32'h0, 32'h0,        32'h3000, 32'h0,    32'h0, 0, 0);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h3004, 32'h3000, 32'd1, 1, 0);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h3008, 32'h3004, 32'd2, 1, 0);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h300C, 32'h3008, 32'd3, 1, 0);
      // Branch from D PC 0x3008, offset 0x10; delay slot 0x300C enters D.
      step(1, 0, 3'd1, 32'h10, 32'h0,       32'h301C, 32'h300C, 32'd4, 1, 0);
      // JR back to 0x3000 after placing a J instruction at IM word 0.
      im_mem[0] = 32'h0800_0C40;
      step(1, 0, 3'd3, 32'h0, 32'h3000,     32'h3000, 32'h301C, 32'd8, 1, 0);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h3004, 32'h3000, 32'h0800_0C40, 1, 0);
      // J from D PC 0x3000 -> 0x3100.
      step(1, 0, 3'd2, 32'h0, 32'h0,        32'h3100, 32'h3004, 32'd2, 1, 0);
      // JR -> 0x3200.
      step(1, 0, 3'd3, 32'h0, 32'h3200,     32'h3200, 32'h3100, 32'h41, 1, 0);
      // Stall two cycles with a branch pending: nothing moves.
      step(1, 1, 3'd1, 32'h20, 32'h0,       32'h3200, 32'h3100, 32'h41, 1, 0);
      step(1, 1, 3'd1, 32'h20, 32'h0,       32'h3200, 32'h3100, 32'h41, 1, 0);
      // Release: branch taken once (0x3100+4+0x20).
      step(1, 0, 3'd1, 32'h20, 32'h0,       32'h3124, 32'h3200, 32'h81, 1, 0);
      // Code 5 behaves as SEQ.
      step(1, 0, 3'd5, 32'h20, 32'h0,       32'h3128, 32'h3124, 32'h4A, 1, 0);
      // Misaligned JR target 0x3102.
      step(1, 0, 3'd3, 32'h0, 32'h3102,     32'h3102, 32'h3128, 32'h4B, 1, 0);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h3106, 32'h3102, 32'h0, 0, 1);
      // Legal JR to 0x3000 while still fetching illegal 0x3106; fault sticks.
      step(1, 0, 3'd3, 32'h0, 32'h3000,     32'h3000, 32'h3106, 32'h0, 0, 1);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h3004, 32'h3000, 32'h0800_0C40, 1, 1);
      // Range boundaries: below base, exactly at limit, last legal word.
      step(1, 0, 3'd3, 32'h0, 32'h2FFC,     32'h2FFC, 32'h3004, 32'd2, 1, 1);
      step(1, 0, 3'd3, 32'h0, 32'h7000,     32'h7000, 32'h2FFC, 32'h0, 0, 1);
      step(1, 0, 3'd3, 32'h0, 32'h6FFC,     32'h6FFC, 32'h7000, 32'h0, 0, 1);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h7000, 32'h6FFC, 32'h1000, 1, 1);
      // Wrap-around of F_PC+4.
      step(1, 0, 3'd3, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h7000, 32'h0, 0, 1);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h0, 32'hFFFF_FFFC, 32'h0, 0, 1);
      // Branch with negative offset from D PC 0xFFFFFFFC: 0x0 + (-8) wraps.
      step(1, 0, 3'd1, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'h0, 0, 1);
      // Reset together with stall and a JR; the monitor first confirms the
      // mid-cycle reset assertion leaves state untouched.
      step(0, 1, 3'd3, 32'h0, 32'h3200,     32'h3000, 32'h0, 32'h0, 0, 0);
      step(1, 0, 3'd0, 32'h0, 32'h0,        32'h3004, 32'h3000, 32'h0800_0C40, 1, 0);

      // Drain the scoreboard with a bounded wait.
      for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
